// File: rtl/snake_game_ctrl_pkg.sv
// Shared direction/state codes and grid defaults for the snake game datapath.
// The renderer and body memory import the same package.
package snake_game_ctrl_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  // DEAD sits above the 2-bit window so out_state (low bits) reports it as 0.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_MOVE  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DEAD  = 3'd4
  } state_e;

  localparam int GRID_W_DEF = 40;
  localparam int GRID_H_DEF = 30;

  // Opposite pairs differ only in bit 0 (UP/DOWN, LEFT/RIGHT).
  function automatic dir_e reverse_dir(input dir_e d);
    return dir_e'({d[1], ~d[0]});
  endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Game-tick divider: pulses tick on the last cycle of each TICK_DIV-cycle window.
// Counter is held at zero whenever enable is low.
module snake_tick_gen #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic in_clock,
  input  logic in_button_reset,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_tc;

  assign w_tc = (r_cnt == CNT_TC);
  assign tick = enable & w_tc;

  always_ff @(posedge in_clock) begin
    if (in_button_reset || !enable || w_tc) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: button edge-detect and heading, tick pacing, head
// movement with wall/self/food handling, and step/grow strobes to body memory.
//
// state | meaning
// IDLE  | waiting for first accepted press, tick counter held at 0
// RUN   | counting game-tick cycles
// MOVE  | commit heading, advance head or die on wall
// CHECK | sample self-hit, issue step/grow/food strobes
// DEAD  | frozen until reset
module snake_game_ctrl
  import snake_game_ctrl_pkg::*;
#(
  parameter int GRID_W    = GRID_W_DEF,
  parameter int GRID_H    = GRID_H_DEF,
  parameter int X_W       = 6,
  parameter int Y_W       = 5,
  parameter int TICK_DIV  = 25_000_000,
  parameter int START_LEN = 3,
  parameter int MAX_LEN   = 64,
  parameter int LEN_W     = $clog2(MAX_LEN + 1)
) (
  input  logic             in_clock,
  input  logic             in_button_reset,
  input  logic             in_button_up,
  input  logic             in_button_down,
  input  logic             in_button_left,
  input  logic             in_button_right,
  input  logic [X_W-1:0]   in_food_x,
  input  logic [Y_W-1:0]   in_food_y,
  input  logic             in_self_hit,
  output logic [X_W-1:0]   out_head_x,
  output logic [Y_W-1:0]   out_head_y,
  output logic [1:0]       out_dir,
  output logic [1:0]       out_state,
  output logic             out_step,
  output logic             out_grow,
  output logic             out_food_req,
  output logic [LEN_W-1:0] out_length
);

  localparam logic [X_W-1:0]   X_MAX     = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0]   Y_MAX     = Y_W'(GRID_H - 1);
  localparam logic [X_W-1:0]   X_START   = X_W'(GRID_W / 2);
  localparam logic [Y_W-1:0]   Y_START   = Y_W'(GRID_H / 2);
  localparam logic [LEN_W-1:0] LEN_START = LEN_W'(START_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_LEN);

  state_e           r_state, w_state_next;
  dir_e             r_dir, r_pend_dir, w_press_dir;
  logic [3:0]       w_btn_in, r_btn_lvl, r_btn_prev, w_press;
  logic             w_accept, w_tick, w_run_en, w_wall, w_food_hit;
  logic [X_W-1:0]   r_head_x, w_next_x;
  logic [Y_W-1:0]   r_head_y, w_next_y;
  logic [LEN_W-1:0] r_length;
  logic             r_step, r_grow, r_food_req;
  logic             w_step_n, w_grow_n, w_food_n;

  // Bit index equals the direction code.
  assign w_btn_in = {in_button_right, in_button_left, in_button_down, in_button_up};
  assign w_press  = r_btn_lvl & ~r_btn_prev;

  always_comb begin
    w_press_dir = DIR_RIGHT;
    if (w_press[0])      w_press_dir = DIR_UP;
    else if (w_press[1]) w_press_dir = DIR_DOWN;
    else if (w_press[2]) w_press_dir = DIR_LEFT;
  end

  assign w_accept = (|w_press) && (w_press_dir != reverse_dir(r_dir)) &&
                    (r_state != ST_DEAD);

  assign w_run_en = (r_state == ST_RUN);

  snake_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .in_clock        (in_clock),
    .in_button_reset (in_button_reset),
    .enable          (w_run_en),
    .tick            (w_tick)
  );

  always_comb begin
    w_next_x = r_head_x;
    w_next_y = r_head_y;
    w_wall   = 1'b0;
    case (r_pend_dir)
      DIR_UP: begin
        w_wall   = (r_head_y == '0);
        w_next_y = r_head_y - Y_W'(1);
      end
      DIR_DOWN: begin
        w_wall   = (r_head_y == Y_MAX);
        w_next_y = r_head_y + Y_W'(1);
      end
      DIR_LEFT: begin
        w_wall   = (r_head_x == '0);
        w_next_x = r_head_x - X_W'(1);
      end
      default: begin
        w_wall   = (r_head_x == X_MAX);
        w_next_x = r_head_x + X_W'(1);
      end
    endcase
  end

  assign w_food_hit = (r_head_x == in_food_x) && (r_head_y == in_food_y);

  always_comb begin
    w_state_next = r_state;
    w_step_n     = 1'b0;
    w_grow_n     = 1'b0;
    w_food_n     = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_next = ST_RUN;
      ST_RUN:   if (w_tick) w_state_next = ST_MOVE;
      ST_MOVE:  w_state_next = w_wall ? ST_DEAD : ST_CHECK;
      ST_CHECK: begin
        if (in_self_hit) begin
          w_state_next = ST_DEAD;
        end else begin
          w_state_next = ST_RUN;
          w_step_n     = 1'b1;
          w_food_n     = w_food_hit;
          w_grow_n     = w_food_hit && (r_length < LEN_MAX);
        end
      end
      default:  w_state_next = ST_DEAD;
    endcase
  end

  always_ff @(posedge in_clock) begin
    if (in_button_reset) r_state <= ST_IDLE;
    else                 r_state <= w_state_next;
  end

  always_ff @(posedge in_clock) begin
    if (in_button_reset) begin
      r_btn_lvl  <= '0;
      r_btn_prev <= '0;
      r_head_x   <= X_START;
      r_head_y   <= Y_START;
      r_dir      <= DIR_RIGHT;
      r_pend_dir <= DIR_RIGHT;
      r_length   <= LEN_START;
      r_step     <= 1'b0;
      r_grow     <= 1'b0;
      r_food_req <= 1'b0;
    end else begin
      r_btn_lvl  <= w_btn_in;
      r_btn_prev <= r_btn_lvl;
      r_step     <= w_step_n;
      r_grow     <= w_grow_n;
      r_food_req <= w_food_n;
      // MOVE reads the old pending heading, so a press landing here waits a tick.
      if (w_accept) r_pend_dir <= w_press_dir;
      if (r_state == ST_MOVE) begin
        r_dir <= r_pend_dir;
        if (!w_wall) begin
          r_head_x <= w_next_x;
          r_head_y <= w_next_y;
        end
      end
      if (w_grow_n) r_length <= r_length + LEN_W'(1);
    end
  end

  assign out_head_x   = r_head_x;
  assign out_head_y   = r_head_y;
  assign out_dir      = r_dir;
  assign out_state    = r_state[1:0];
  assign out_step     = r_step;
  assign out_grow     = r_grow;
  assign out_food_req = r_food_req;
  assign out_length   = r_length;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Bench for snake_game_ctrl: directed scenarios plus a randomized run checked
// against a cycle-level game model built from the game rules.
module tb_snake_game_ctrl;

  localparam int GW = 8;
  localparam int GH = 8;
  localparam int TD = 4;
  localparam int SL = 3;
  localparam int ML = 4;
  localparam int XW = 6;
  localparam int YW = 5;
  localparam int LW = $clog2(ML + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          up = 1'b0, dn = 1'b0, lf = 1'b0, rt = 1'b0;
  logic [XW-1:0] fx = '0;
  logic [YW-1:0] fy = '0;
  logic          self_hit = 1'b0;

  logic [XW-1:0] out_head_x;
  logic [YW-1:0] out_head_y;
  logic [1:0]    out_dir, out_state;
  logic          out_step, out_grow, out_food_req;
  logic [LW-1:0] out_length;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  snake_game_ctrl #(
    .GRID_W(GW), .GRID_H(GH), .X_W(XW), .Y_W(YW), .TICK_DIV(TD),
    .START_LEN(SL), .MAX_LEN(ML)
  ) dut (
    .in_clock(clk), .in_button_reset(rst),
    .in_button_up(up), .in_button_down(dn),
    .in_button_left(lf), .in_button_right(rt),
    .in_food_x(fx), .in_food_y(fy), .in_self_hit(self_hit),
    .out_head_x(out_head_x), .out_head_y(out_head_y), .out_dir(out_dir),
    .out_state(out_state), .out_step(out_step), .out_grow(out_grow),
    .out_food_req(out_food_req), .out_length(out_length)
  );

  // Game model: mode 0 idle, 1 playing, 2 dead. While playing, m_cyc counts
  // position in the TD+2 cycle period: 0..TD-1 running, TD move, TD+1 check.
  int       m_mode, m_cyc, m_hx, m_hy, m_dir, m_pend, m_len;
  bit       m_step, m_grow, m_food;
  bit [3:0] m_seen, m_seen_prev;

  task automatic model_step();
    bit [3:0] press;
    int       pd;
    bit       acc;
    int       nx, ny;
    press = m_seen & ~m_seen_prev;
    pd = -1;
    for (int i = 0; i < 4; i++) if (press[i] && pd < 0) pd = i;
    acc = (pd >= 0) && (pd != (m_dir ^ 1)) && (m_mode != 2);
    m_step = 0; m_grow = 0; m_food = 0;
    if (rst) begin
      m_mode = 0; m_cyc = 0; m_hx = GW / 2; m_hy = GH / 2;
      m_dir = 3; m_pend = 3; m_len = SL; m_seen = 0; m_seen_prev = 0;
      return;
    end
    if (m_mode == 0) begin
      if (acc) begin m_mode = 1; m_cyc = 0; end
    end else if (m_mode == 1) begin
      if (m_cyc < TD) begin
        m_cyc++;
      end else if (m_cyc == TD) begin
        nx = m_hx; ny = m_hy;
        case (m_pend)
          0: ny = ny - 1;
          1: ny = ny + 1;
          2: nx = nx - 1;
          default: nx = nx + 1;
        endcase
        m_dir = m_pend;
        if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) m_mode = 2;
        else begin m_hx = nx; m_hy = ny; m_cyc = TD + 1; end
      end else begin
        if (self_hit) m_mode = 2;
        else begin
          m_step = 1;
          if (m_hx == int'(fx) && m_hy == int'(fy)) begin
            m_food = 1;
            if (m_len < ML) begin m_grow = 1; m_len++; end
          end
          m_cyc = 0;
        end
      end
    end
    if (acc) m_pend = pd;
    m_seen_prev = m_seen;
    m_seen = {rt, lf, dn, up};
  endtask

  always @(posedge clk) model_step();

  function automatic int exp_state();
    if (m_mode != 1) return 0;
    if (m_cyc < TD)  return 1;
    if (m_cyc == TD) return 2;
    return 3;
  endfunction

  task automatic do_reset();
    rst = 1; up = 0; dn = 0; lf = 0; rt = 0; self_hit = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic press_right();
    rt = 1;
    @(negedge clk);
    rt = 0;
  endtask

  task automatic wait_step(input int budget, output bit ok);
    int n;
    n = 0; ok = 0;
    while (!ok && n < budget) begin
      @(negedge clk);
      n++;
      ok = (out_step === 1'b1);
    end
  endtask

  task automatic wait_check_state(input int budget, output bit ok);
    int n;
    n = 0; ok = (out_state === 2'd3);
    while (!ok && n < budget) begin
      @(negedge clk);
      n++;
      ok = (out_state === 2'd3);
    end
  endtask

  task automatic test_reset();
    int bad;
    do_reset();
    n_tests++;
    if ({out_head_x, out_head_y} !== {XW'(4), YW'(4)} || out_dir !== 2'd3 ||
        out_length !== LW'(3) || out_state !== 2'd0)
      begin n_fail++; $display("FAIL reset_values: head=(%0d,%0d) dir=%0d len=%0d st=%0d, want (4,4) 3 3 0",
        out_head_x, out_head_y, out_dir, out_length, out_state); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_step || out_grow || out_food_req || out_state !== 2'd0) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL reset_quiet: %0d bad cycles, want 0", bad); end
  endtask

  task automatic test_move_right();
    int exp_st[8] = '{0, 1, 1, 1, 1, 2, 3, 1};
    press_right();
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      n_tests++;
      if (out_state !== 2'(exp_st[k-1]) || out_step !== (k == 8))
        begin n_fail++; $display("FAIL move_seq k=%0d: st=%0d step=%0d, want st=%0d step=%0d",
          k, out_state, out_step, exp_st[k-1], (k == 8)); end
    end
    n_tests++;
    if (out_head_x !== XW'(5) || out_head_y !== YW'(4) || out_dir !== 2'd3)
      begin n_fail++; $display("FAIL move_first: head=(%0d,%0d) dir=%0d, want (5,4) 3",
        out_head_x, out_head_y, out_dir); end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      n_tests++;
      if (out_step !== (k == 6))
        begin n_fail++; $display("FAIL move_period k=%0d: step=%0d want %0d", k, out_step, (k == 6)); end
    end
    n_tests++;
    if (out_head_x !== XW'(6) || out_head_y !== YW'(4))
      begin n_fail++; $display("FAIL move_second: head=(%0d,%0d), want (6,4)", out_head_x, out_head_y); end
  endtask

  task automatic test_turn();
    bit ok;
    lf = 1; @(negedge clk);
    lf = 0; up = 1; @(negedge clk);
    up = 0; lf = 1; @(negedge clk);
    lf = 0;
    wait_step(12, ok);
    n_tests++;
    if (!ok || out_head_x !== XW'(6) || out_head_y !== YW'(3) || out_dir !== 2'd0)
      begin n_fail++; $display("FAIL turn_up: ok=%0d head=(%0d,%0d) dir=%0d, want (6,3) 0",
        ok, out_head_x, out_head_y, out_dir); end
  endtask

  task automatic test_wall();
    bit ok;
    int bad;
    do_reset();
    press_right();
    for (int s = 5; s <= 7; s++) begin
      wait_step(12, ok);
      n_tests++;
      if (!ok || out_head_x !== XW'(s))
        begin n_fail++; $display("FAIL wall_approach: ok=%0d x=%0d, want %0d", ok, out_head_x, s); end
    end
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      up = (i == 12); dn = (i == 16); rt = (i == 20);
      @(negedge clk);
      if (out_step !== 1'b0 || out_head_x !== XW'(7) || out_head_y !== YW'(4) ||
          (i >= 8 && out_state !== 2'd0)) bad++;
    end
    up = 0; dn = 0; rt = 0;
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL wall_dead: %0d bad cycles, want 0", bad); end
  endtask

  task automatic test_food();
    bit ok;
    do_reset();
    fx = XW'(5); fy = YW'(4);
    press_right();
    wait_step(12, ok);
    n_tests++;
    if (!ok || {out_grow, out_food_req} !== 2'b11 || out_length !== LW'(4))
      begin n_fail++; $display("FAIL food_grow: ok=%0d grow=%0d food=%0d len=%0d, want 1 1 4",
        ok, out_grow, out_food_req, out_length); end
    fx = XW'(6);
    @(negedge clk);
    n_tests++;
    if ({out_step, out_grow, out_food_req} !== 3'b000)
      begin n_fail++; $display("FAIL food_pulse_width: %b want 000", {out_step, out_grow, out_food_req}); end
    wait_step(12, ok);
    n_tests++;
    if (!ok || out_grow !== 1'b0 || out_food_req !== 1'b1 || out_length !== LW'(4))
      begin n_fail++; $display("FAIL food_saturate: ok=%0d grow=%0d food=%0d len=%0d, want 0 1 4",
        ok, out_grow, out_food_req, out_length); end
    fx = '0; fy = '0;
    wait_step(12, ok);
    n_tests++;
    if (!ok || out_grow !== 1'b0 || out_food_req !== 1'b0 || out_head_x !== XW'(7))
      begin n_fail++; $display("FAIL food_miss: ok=%0d grow=%0d food=%0d x=%0d, want 0 0 7",
        ok, out_grow, out_food_req, out_head_x); end
  endtask

  task automatic test_self_hit();
    bit ok;
    int bad;
    do_reset();
    press_right();
    wait_check_state(12, ok);
    self_hit = 1;
    @(negedge clk);
    self_hit = 0;
    n_tests++;
    if (!ok || out_step !== 1'b0 || out_state !== 2'd0)
      begin n_fail++; $display("FAIL self_hit: ok=%0d step=%0d st=%0d, want 0 0", ok, out_step, out_state); end
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_step !== 1'b0 || out_state !== 2'd0 || out_head_x !== XW'(5)) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL self_hit_dead: %0d bad cycles, want 0", bad); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    press_right();
    wait_step(12, ok);
    @(negedge clk); @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    n_tests++;
    if (!ok || out_state !== 2'd0 || out_head_x !== XW'(4) || out_head_y !== YW'(4) ||
        out_length !== LW'(3) || out_dir !== 2'd3)
      begin n_fail++; $display("FAIL reset_mid_run: ok=%0d st=%0d head=(%0d,%0d) len=%0d dir=%0d, want 0 (4,4) 3 3",
        ok, out_state, out_head_x, out_head_y, out_length, out_dir); end
    press_right();
    wait_check_state(12, ok);
    rst = 1;
    @(negedge clk);
    rst = 0;
    n_tests++;
    if (!ok || out_step !== 1'b0 || out_state !== 2'd0 || out_head_x !== XW'(4))
      begin n_fail++; $display("FAIL reset_mid_check: ok=%0d step=%0d st=%0d x=%0d, want 0 0 4",
        ok, out_step, out_state, out_head_x); end
  endtask

  task automatic test_random();
    logic [XW+YW+2+2+3+LW-1:0] got, exp;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      got = {out_head_x, out_head_y, out_dir, out_state, out_step, out_grow, out_food_req, out_length};
      exp = {XW'(m_hx), YW'(m_hy), 2'(m_dir), 2'(exp_state()), m_step, m_grow, m_food, LW'(m_len)};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %h want %h", c, got, exp);
      end
      rst = (m_mode == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 299) == 0);
      up = ($urandom_range(0, 5) == 0);
      dn = ($urandom_range(0, 5) == 0);
      lf = ($urandom_range(0, 5) == 0);
      rt = ($urandom_range(0, 5) == 0);
      self_hit = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 3) == 0) begin
        fx = XW'($urandom_range(2, 6));
        fy = YW'($urandom_range(2, 6));
      end
    end
    rst = 0; up = 0; dn = 0; lf = 0; rt = 0; self_hit = 0;
  endtask

  initial begin
    test_reset();
    test_move_right();
    test_turn();
    test_wall();
    test_food();
    test_self_hit();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
